// File: rtl/alu_serial_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl_if
//
// Purpose: operand request / result response bus of the bit-serial ALU
// sequencer, bundled so the sequencer and its user share one port.
//
// Signals (WIDTH = operand/result width):
//   in_valid, in_ready        request handshake
//   src1, src2, alu_ctrl      operands and operation code
//   out_valid, out_ready      response handshake
//   result, zero, cout, overflow  registered result and flags
//
// Modports:
//   master - drives requests, consumes results (user side)
//   slave  - accepts requests, produces results (alu_serial_ctrl side)
// ---------------------------------------------------------------------------
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, src1, src2, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow
  );

  modport slave (
    input  in_valid, src1, src2, alu_ctrl, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow
  );

endinterface

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Purpose: executes one WIDTH-bit ALU operation by driving a single external
// 1-bit ALU slice one bit position per clock, LSB first. Owns the carry flop
// and the result assembly register; presents a valid/ready operand interface
// and a registered result with zero/cout/overflow flags.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   bus (slave)      in_valid/in_ready/src1/src2/alu_ctrl request,
//                    out_valid/out_ready/result/zero/cout/overflow response
//   slice_src1/2     current bit of latched A / B
//   slice_less       tied 0 (set-less-than is resolved here, not in the slice)
//   slice_a_invert,
//   slice_b_invert   invert controls
//   slice_cin        carry flop
//   slice_operation  00 AND, 01 OR, 10 ADD, 11 LESS
//   slice_result,
//   slice_cout,
//   slice_set_less   combinational slice outputs
//
// alu_ctrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
// Any other code yields result 0 with zero=1 and the same latency.
//
// Build option: define SLT_OVF_FIX_EN to correct SLT for signed overflow
// (lt = set_less ^ overflow); otherwise SLT returns the raw MSB of A-B.
//
// WIDTH must match the WIDTH of the connected alu_serial_ctrl_if.
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_serial_ctrl_if.slave    bus,
  output logic                slice_src1,
  output logic                slice_src2,
  output logic                slice_less,
  output logic                slice_a_invert,
  output logic                slice_b_invert,
  output logic                slice_cin,
  output logic [1:0]          slice_operation,
  input  logic                slice_result,
  input  logic                slice_cout,
  input  logic                slice_set_less
);

  // Index runs 0..WIDTH: 0..WIDTH-1 are bit cycles, WIDTH is the finishing
  // cycle in which the result/flags are formed from the captured MSB data.
  localparam int IDX_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       a_inv;
    logic       b_inv;
    logic       known;  // listed opcode; unknown codes zero the operands
    logic       arith;  // ADD/SUB/SLT: overflow is meaningful
    logic       sub;    // carry-in of 1 to form A + ~B + 1
    logic       slt;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] code);
    dec_t d;
    d = '0;
    case (code)
      4'b0000: d.known = 1'b1;
      4'b0001: begin d.known = 1'b1; d.op = 2'b01; end
      4'b0010: begin d.known = 1'b1; d.op = 2'b10; d.arith = 1'b1; end
      4'b0110: begin
        d.known = 1'b1; d.op = 2'b10; d.arith = 1'b1;
        d.b_inv = 1'b1; d.sub = 1'b1;
      end
      4'b0111: begin
        d.known = 1'b1; d.op = 2'b10; d.arith = 1'b1;
        d.b_inv = 1'b1; d.sub = 1'b1; d.slt = 1'b1;
      end
      4'b1100: begin d.known = 1'b1; d.a_inv = 1'b1; d.b_inv = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, acc_next, result_reg;
  logic [3:0]       ctrl_reg;
  logic             carry_reg, cin_msb_reg, cout_msb_reg, sl_reg;
  logic             in_ready_reg, out_valid_reg, zero_reg, cout_reg, overflow_reg;
  logic             in_ready_next, out_valid_next;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] res_final;
  logic             bit_active, last_bit, fin_cycle, ovf, lt;
  dec_t             dec;

  // In IDLE the incoming code is decoded (carry-in, operand masking);
  // afterwards the captured code drives everything.
  assign dec = decode((state_reg == IDLE) ? bus.alu_ctrl : ctrl_reg);

  assign last_bit   = (idx_reg == IDX_W'(WIDTH - 1));
  assign fin_cycle  = (idx_reg == IDX_W'(WIDTH));
  assign bit_active = (state_reg == RUN) && !fin_cycle;

  // One-hot bit select and result bit write-back.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sel_mask[gi] = (idx_reg == IDX_W'(gi));
      assign acc_next[gi] = (bit_active && sel_mask[gi]) ? slice_result : acc_reg[gi];
    end
  endgenerate

  // Final result / SLT resolution from the captured MSB information.
  always_comb begin
    ovf = cin_msb_reg ^ cout_msb_reg;
`ifdef SLT_OVF_FIX_EN
    lt  = sl_reg ^ ovf;
`else
    lt  = sl_reg;
`endif
    res_final = dec.slt ? {{(WIDTH-1){1'b0}}, lt} : acc_reg;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (fin_cycle)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Handshake outputs are computed from the next state and registered so
  // that they come straight from flops (and read 0 while in reset).
  always_comb begin
    in_ready_next   = (state_next == IDLE);
    out_valid_next  = (state_next == DONE);
    slice_src1      = 1'b0;
    slice_src2      = 1'b0;
    slice_less      = 1'b0;
    slice_a_invert  = 1'b0;
    slice_b_invert  = 1'b0;
    slice_cin       = 1'b0;
    slice_operation = 2'b00;
    if (bit_active) begin
      slice_src1      = |(a_reg & sel_mask);
      slice_src2      = |(b_reg & sel_mask);
      slice_a_invert  = dec.a_inv;
      slice_b_invert  = dec.b_inv;
      slice_cin       = carry_reg;
      slice_operation = dec.op;
    end
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      ctrl_reg      <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      cin_msb_reg   <= 1'b0;
      cout_msb_reg  <= 1'b0;
      sl_reg        <= 1'b0;
      zero_reg      <= 1'b0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= dec.known ? bus.src1 : '0;
            b_reg     <= dec.known ? bus.src2 : '0;
            ctrl_reg  <= bus.alu_ctrl;
            idx_reg   <= '0;
            carry_reg <= dec.sub;
            acc_reg   <= '0;
          end
        end
        RUN: begin
          if (!fin_cycle) begin
            acc_reg   <= acc_next;
            carry_reg <= slice_cout;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (last_bit) begin
              cin_msb_reg  <= carry_reg;
              cout_msb_reg <= slice_cout;
              sl_reg       <= slice_set_less;
            end
          end else begin
            result_reg   <= res_final;
            zero_reg     <= (res_final == '0);
            cout_reg     <= dec.arith & ~dec.slt & cout_msb_reg;
            overflow_reg <= dec.arith & ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
//
// Self-checking bench for alu_serial_ctrl (WIDTH=32). Contains a behavioural
// 1-bit ALU slice connected to the slice_* ports, a table of directed
// vectors with hand-computed results, and hand-written sequences for
// result back-pressure and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

  logic       slice_src1, slice_src2, slice_less, slice_a_invert, slice_b_invert, slice_cin;
  logic [1:0] slice_operation;
  logic       slice_result, slice_cout, slice_set_less;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .slice_src1      (slice_src1),
    .slice_src2      (slice_src2),
    .slice_less      (slice_less),
    .slice_a_invert  (slice_a_invert),
    .slice_b_invert  (slice_b_invert),
    .slice_cin       (slice_cin),
    .slice_operation (slice_operation),
    .slice_result    (slice_result),
    .slice_cout      (slice_cout),
    .slice_set_less  (slice_set_less)
  );

  // External 1-bit ALU slice.
  logic sa, sb, ssum;
  always_comb begin
    sa             = slice_src1 ^ slice_a_invert;
    sb             = slice_src2 ^ slice_b_invert;
    ssum           = sa ^ sb ^ slice_cin;
    slice_cout     = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
    slice_set_less = ssum;
    case (slice_operation)
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = ssum;
      default: slice_result = slice_less;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] slice_pack();
    return {slice_src1, slice_src2, slice_less, slice_a_invert, slice_b_invert,
            slice_cin, slice_operation, 1'b0};
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait for out_valid
  // and check its latency. Leaves out_valid pending for the caller.
  task automatic run_op(input string name, input logic [3:0] ctrl,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output bit got);
    bit ok;
    int lat;
    got = 1'b0;
    wait_ready(ok);
    check({name, " ready"}, WIDTH'(ok), WIDTH'(1));
    if (!ok) return;
    bus.in_valid = 1'b1; bus.src1 = a; bus.src2 = b; bus.alu_ctrl = ctrl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src1 = $urandom; bus.src2 = $urandom; bus.alu_ctrl = 4'($urandom);
    check({name, " busy"}, WIDTH'(bus.in_ready), '0);
    lat = 0;
    while (lat < 100 && !got) begin
      @(posedge clk); #1;
      lat++;
      got = bus.out_valid;
    end
    check({name, " latency"}, WIDTH'(lat), WIDTH'(WIDTH + 1));
  endtask

  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, " out_valid drop"}, WIDTH'(bus.out_valid), '0);
    check({name, " in_ready back"}, WIDTH'(bus.in_ready), WIDTH'(1));
  endtask

  typedef struct {
    string            name;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a, b, res;
    logic             z, c, v;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int spurious;

    vecs[0]  = '{"add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"sub_eq",   OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{"nor",      OP_NOR, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"or",       OP_OR,  32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"and",      OP_AND, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1'b0, 1'b0, 1'b0};
`ifdef SLT_OVF_FIX_EN
    vecs[5]  = '{"slt_ovf",  OP_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1};
`else
    vecs[5]  = '{"slt_ovf",  OP_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1};
`endif
    vecs[6]  = '{"slt_neg",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{"sub_neg",  OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"sub_ovf",  OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"unlisted", 4'b1111, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"nor_zero", OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"slt_small", OP_SLT, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.alu_ctrl = '0; bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready",  WIDTH'(bus.in_ready),  '0);
    check("rst out_valid", WIDTH'(bus.out_valid), '0);
    check("rst result",    bus.result,            '0);
    check("rst flags",     WIDTH'({bus.zero, bus.cout, bus.overflow}), '0);
    check("rst slice",     WIDTH'(slice_pack()),  '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst in_ready", WIDTH'(bus.in_ready), WIDTH'(1));

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, got);
      if (got) begin
        check({vecs[i].name, " result"},   bus.result,             vecs[i].res);
        check({vecs[i].name, " zero"},     WIDTH'(bus.zero),       WIDTH'(vecs[i].z));
        check({vecs[i].name, " cout"},     WIDTH'(bus.cout),       WIDTH'(vecs[i].c));
        check({vecs[i].name, " overflow"}, WIDTH'(bus.overflow),   WIDTH'(vecs[i].v));
        $display("op %-9s a=%08h b=%08h -> result=%08h z=%0b c=%0b v=%0b", vecs[i].name,
                 vecs[i].a, vecs[i].b, bus.result, bus.zero, bus.cout, bus.overflow);
      end
      release_result(vecs[i].name);
    end

    // Back-pressure: result held, new requests ignored while waiting
    run_op("stall", OP_ADD, 32'd3, 32'd4, got);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.src1 = 32'd1; bus.src2 = 32'd1; bus.alu_ctrl = OP_AND;
      @(posedge clk); #1;
      check("stall result",    bus.result,            32'd7);
      check("stall out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
      check("stall in_ready",  WIDTH'(bus.in_ready),  '0);
    end
    bus.in_valid = 1'b0;
    release_result("stall");
    $display("op stall     held 10 cycles, result=%08h", 32'd7);
    run_op("after_stall", OP_AND, 32'h000000F0, 32'h0000003C, got);
    check("after_stall result", bus.result, 32'h00000030);
    release_result("after_stall");

    // Reset asserted while bit 12 of an ADD is on the slice
    begin
      bit ok;
      wait_ready(ok);
      check("mid-rst ready", WIDTH'(ok), WIDTH'(1));
      bus.in_valid = 1'b1; bus.src1 = 32'h7FFFFFFF; bus.src2 = 32'h00000001; bus.alu_ctrl = OP_ADD;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("bit12 src1", WIDTH'(slice_src1),      WIDTH'(1));
      check("bit12 src2", WIDTH'(slice_src2),      '0);
      check("bit12 op",   WIDTH'(slice_operation), WIDTH'(2));
      rst_n = 1'b0;
      #1;
      check("mid-rst in_ready",  WIDTH'(bus.in_ready),  '0);
      check("mid-rst out_valid", WIDTH'(bus.out_valid), '0);
      check("mid-rst result",    bus.result,            '0);
      check("mid-rst flags",     WIDTH'({bus.zero, bus.cout, bus.overflow}), '0);
      check("mid-rst slice",     WIDTH'(slice_pack()),  '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid) spurious++;
      end
      check("mid-rst no out_valid", WIDTH'(spurious), '0);
      $display("op midreset  discarded, spurious out_valid cycles=%0d", spurious);
    end
    run_op("post_rst_sub", OP_SUB, 32'h00000005, 32'h00000005, got);
    check("post_rst_sub result", bus.result,       '0);
    check("post_rst_sub zero",   WIDTH'(bus.zero), WIDTH'(1));
    check("post_rst_sub cout",   WIDTH'(bus.cout), WIDTH'(1));
    release_result("post_rst_sub");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer that executes one WIDTH-bit ALU operation by driving a single external 1-bit ALU slice (AND/OR/ADD/LESS slice with A/B invert, carry-in, carry-out and set_less) one bit position per clock, LSB first. It sits directly upstream of that slice, owns the carry flop and the result shift register, and presents a valid/ready operand interface and a registered result with zero/cout/overflow flags. It trades latency for area: one slice instead of WIDTH.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- src1  input  WIDTH  operand A
- src2  input  WIDTH  operand B
- alu_ctrl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- out_valid  output  1  result, zero, cout, overflow valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- cout  output  1  carry out of MSB (ADD/SUB only, else 0)
- overflow  output  1  signed overflow (ADD/SUB/SLT only, else 0)
- slice_src1, slice_src2  output  1  current bit of A, B
- slice_less  output  1  always 0 (SLT resolved internally)
- slice_a_invert, slice_b_invert  output  1  invert controls
- slice_cin  output  1  carry flop value
- slice_operation  output  2  00 AND, 01 OR, 10 ADD, 11 LESS
- slice_result, slice_cout, slice_set_less  input  1  slice outputs (combinational from slice_* outputs)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: latch src1, src2, alu_ctrl; bit index ← 0; carry ← 1 for SUB/SLT, else 0; → RUN.
- Decode: AND op00 inv 0/0; OR op01 inv 0/0; ADD op10 inv 0/0; SUB op10 b_invert=1; SLT op10 b_invert=1; NOR op00 inv 1/1. Unlisted codes: op00 inv 0/0 with captured bits forced to 0 (result 0, zero 1, flags 0), same latency.
- RUN: slice_src1/src2 = latched bit[index]. Each cycle: result bit[index] ← slice_result; carry ← slice_cout; index+1. At index=WIDTH-1: capture cin_msb=carry, cout_msb=slice_cout, sl=slice_set_less; → DONE.
- Overflow = cin_msb ^ cout_msb for ADD/SUB/SLT.
- SLT: result ← {WIDTH-1 zeros, lt}; lt per Configuration. cout=0 for SLT.
- DONE: out_valid=1; result/flags stable. On out_ready → IDLE.
- in_ready=0 in RUN and DONE; in_valid ignored there. src/alu_ctrl changes after acceptance have no effect.
- Reset values: in_ready 0 while rst_n low then 1 in IDLE; out_valid 0, result 0, zero 0, cout 0, overflow 0, all slice_* outputs 0.
- Reset asserted mid-RUN or in DONE: operation discarded, all state cleared immediately, no out_valid.

## Timing
- Acceptance at edge T (in_valid & in_ready); bit k presented to slice in cycle T+1+k; out_valid high from edge T+WIDTH+1.
- out_valid held with stable data until out_ready sampled high; deasserts next edge; in_ready high that same edge.
- Minimum issue interval WIDTH+2 cycles. Slice path is purely combinational within one cycle; all block outputs except slice_* driven from flops.

## Configuration
- SLT_OVF_FIX_EN defined: lt = sl ^ overflow (correct signed compare).
- Undefined: lt = sl (raw MSB of A−B, matches slice set_less semantics; wrong on overflow).

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, cout 0, zero 0, out_valid at T+33.
- SUB 0x00000005 − 0x00000005 → result 0, zero 1, cout 1, overflow 0.
- NOR 0x0F0F0F0F, 0x00FF00FF → 0xF000F000; OR same → 0x0FFF0FFF; AND → 0x000F000F; flags 0.
- SLT 0x7FFFFFFF vs 0xFFFFFFFF → 0 with SLT_OVF_FIX_EN, 1 without; SLT 0xFFFFFFFF vs 0x00000001 → 1 both builds.
- out_ready held low 10 cycles after out_valid → result stable, in_ready 0, new in_valid ignored; release → IDLE next edge, next op accepted.
- rst_n pulsed low at bit 12 of an ADD → all outputs 0 immediately, no out_valid; new op after release completes correctly.
